// File: rtl/seq1010_pkg.sv
// Shared framing constants for the 1010 transmitter and its line-side consumers.
// The recognizer and any destuffing receiver reuse these definitions.
package seq1010_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        DATA,
        GAP
    } state_e;

    localparam logic [3:0] PREAMBLE         = 4'b1010;
    localparam logic [2:0] STUFF_TRIG       = 3'b101;
    localparam logic [2:0] HIST_AFTER_PRE   = 3'b010;
    localparam logic [2:0] HIST_AFTER_STUFF = 3'b011;

endpackage

// File: rtl/seq1010_tx.sv
// Serial frame transmitter: preamble 1010, MSB-first payload with bit-stuffing
// after every 101, then GAP idle zeros. 1010 appears once per frame on the line.
module seq1010_tx #(
    parameter int DATA_W = 8,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid,
    output logic              ready,
    output logic              out,
    output logic              frame_done,
    output logic              busy
);
    import seq1010_pkg::*;

    localparam int CNT_W  = $clog2(DATA_W + 1);
    localparam int GCNT_W = $clog2(GAP + 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GCNT_W-1:0]   gap_q, gap_d;
    logic [1:0]          pre_q, pre_d;
    logic [2:0]          hist_q, hist_d;
    logic                out_q, out_d;
    logic                done_q, done_d;
    logic                data_bit;
    logic [2:0]          hist_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            pre_q   <= '0;
            hist_q  <= '0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            pre_q   <= pre_d;
            hist_q  <= hist_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        pre_d      = pre_q;
        hist_d     = hist_q;
        out_d      = 1'b0;
        done_d     = 1'b0;
        data_bit   = shreg_q[DATA_W-1];
        hist_shift = {hist_q[1:0], shreg_q[DATA_W-1]};

        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    shreg_d = data_in;
                    cnt_d   = CNT_W'(DATA_W);
                    out_d   = PREAMBLE[3];
                    pre_d   = 2'd1;
                    state_d = PRE;
                end
            end
            PRE: begin
                out_d = PREAMBLE[2'd3 - pre_q];
                pre_d = pre_q + 2'd1;
                if (pre_q == 2'd3) begin
                    hist_d  = HIST_AFTER_PRE;
                    state_d = DATA;
                end
            end
            DATA: begin
                // A stuff owed after the final data bit is still sent, so the
                // stuff test must precede the exit test.
                if (hist_q == STUFF_TRIG) begin
                    out_d  = 1'b1;
                    hist_d = HIST_AFTER_STUFF;
                    done_d = (cnt_q == '0);
                end else if (cnt_q == '0) begin
                    gap_d   = GCNT_W'(GAP - 1);
                    state_d = seq1010_pkg::GAP;
                end else begin
                    out_d   = data_bit;
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    hist_d  = hist_shift;
                    done_d  = (cnt_q == CNT_W'(1)) && (hist_shift != STUFF_TRIG);
                end
            end
            seq1010_pkg::GAP: begin
                if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GCNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready      = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out        = out_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_seq1010_tx.sv
// Self-checking bench for seq1010_tx: expected line bits are queued per word
// and popped as the transmitter drives them.
module tb_seq1010_tx;

    localparam int W = 8;
    localparam int G = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         valid = 1'b0;
    logic         ready, out, frame_done, busy;

    int  total = 0;
    int  bad   = 0;
    bit  exp_q[$];
    logic [3:0] line = '0;

    seq1010_tx #(.DATA_W(W), .GAP(G)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .valid      (valid),
        .ready      (ready),
        .out        (out),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        line = {line[2:0], out};
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(v[i]);
    endtask

    // Reference framing: stuff a 1 whenever the last three line bits are 101.
    task automatic push_model(input logic [W-1:0] d, output int n);
        logic [2:0] h;
        bit         b;
        h = 3'b000;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            b = (i % 2 == 0);
            exp_q.push_back(b);
            h = {h[1:0], b};
            n++;
        end
        for (int i = W - 1; i >= 0; i--) begin
            if (h == 3'b101) begin
                exp_q.push_back(1'b1);
                h = {h[1:0], 1'b1};
                n++;
            end
            exp_q.push_back(d[i]);
            h = {h[1:0], d[i]};
            n++;
        end
        if (h == 3'b101) begin
            exp_q.push_back(1'b1);
            n++;
        end
    endtask

    task automatic run_frame(input logic [W-1:0] d, input int n, input bit hold,
                             input logic [W-1:0] next_d);
        bit         got[$];
        bit         e;
        logic [2:0] h;
        logic [W-1:0] w;
        int         nb;
        total++;
        if (ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_before_hs: got=%b exp=1", ready);
        end
        data_in = d;
        valid   = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 0) begin
                if (!hold) valid = 1'b0;
                data_in = next_d;
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL scoreboard_empty: bit=%0d", i);
                e = 1'b0;
            end else begin
                e = exp_q.pop_front();
            end
            if (out !== e) begin
                bad++;
                $display("FAIL out_bit: word=%h bit=%0d got=%b exp=%b", d, i, out, e);
            end
            total++;
            if (frame_done !== (i == n - 1)) begin
                bad++;
                $display("FAIL frame_done: word=%h bit=%0d got=%b exp=%b", d, i, frame_done, (i == n - 1));
            end
            total++;
            if (busy !== 1'b1 || ready !== 1'b0) begin
                bad++;
                $display("FAIL busy_in_frame: bit=%0d got busy=%b ready=%b exp busy=1 ready=0", i, busy, ready);
            end
            total++;
            if ((line == 4'b1010) !== (i == 3)) begin
                bad++;
                $display("FAIL pattern_1010: word=%h bit=%0d got=%b exp=%b", d, i, (line == 4'b1010), (i == 3));
            end
            got.push_back(out);
        end
        for (int g = 0; g < G; g++) begin
            tick();
            total++;
            if (out !== 1'b0 || frame_done !== 1'b0 || ready !== 1'b0 || line == 4'b1010) begin
                bad++;
                $display("FAIL gap: cycle=%0d got out=%b done=%b ready=%b exp out=0 done=0 ready=0", g, out, frame_done, ready);
            end
        end
        tick();
        total++;
        if (ready !== 1'b1 || busy !== 1'b0 || out !== 1'b0) begin
            bad++;
            $display("FAIL ready_after_gap: got ready=%b busy=%b out=%b exp ready=1 busy=0 out=0", ready, busy, out);
        end
        // Receiver view: drop the bit after every 101 once past the preamble.
        h  = 3'b000;
        w  = '0;
        nb = 0;
        for (int k = 0; k < got.size(); k++) begin
            if (k >= 4 && h != 3'b101) begin
                w = {w[W-2:0], got[k]};
                nb++;
            end
            h = {h[1:0], got[k]};
        end
        total++;
        if (w !== d || nb != W) begin
            bad++;
            $display("FAIL destuff: got=%h (%0d bits) exp=%h (%0d bits)", w, nb, d, W);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        total++;
        if (out !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL in_reset: got out=%b busy=%b done=%b exp 0 0 0", out, busy, frame_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if (out !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
                bad++;
                $display("FAIL idle: cycle=%0d got out=%b ready=%b busy=%b done=%b exp 0 1 0 0", i, out, ready, busy, frame_done);
            end
        end
    endtask

    task automatic test_patterns();
        push_bits(32'b101011011001011, 15);
        run_frame(8'hA5, 15, 1'b0, 8'hA5);
        push_bits(32'b101000000000, 12);
        run_frame(8'h00, 12, 1'b0, 8'h00);
        push_bits(32'b1010111111111, 13);
        run_frame(8'hFF, 13, 1'b0, 8'hFF);
    endtask

    task automatic test_back_to_back();
        int n2;
        push_bits(32'b101011011001011, 15);
        push_model(8'h5A, n2);
        run_frame(8'hA5, 15, 1'b1, 8'h5A);
        run_frame(8'h5A, n2, 1'b0, 8'h5A);
    endtask

    task automatic test_reset_mid();
        int n;
        push_model(8'hC3, n);
        data_in = 8'hC3;
        valid   = 1'b1;
        tick();
        valid = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got out=%b ready=%b busy=%b done=%b exp 0 1 0 0", out, ready, busy, frame_done);
        end
        exp_q.delete();
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (frame_done !== 1'b0 || out !== 1'b0) begin
                bad++;
                $display("FAIL held_reset: got out=%b done=%b exp 0 0", out, frame_done);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        line  = '0;
        tick();
        push_model(8'h3C, n);
        run_frame(8'h3C, n, 1'b0, 8'h3C);
    endtask

    task automatic test_random();
        logic [W-1:0] cur, nxt;
        int  n;
        bit  hold;
        cur = W'($urandom);
        for (int i = 0; i < 1000; i++) begin
            push_model(cur, n);
            nxt  = W'($urandom);
            hold = (i < 999) && ($urandom_range(0, 1) == 1);
            run_frame(cur, n, hold, nxt);
            if (!hold) begin
                valid = 1'b0;
                for (int k = 0; k < int'($urandom_range(0, 2)); k++) tick();
            end
            cur = nxt;
        end
        valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_patterns();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
